// File: rtl/adder_digit_serial_pkg.sv
// rtl/adder_digit_serial_pkg.sv - shared state encoding and sizing helper for the digit-serial adder
package adder_digit_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Digit counter width; a single-digit adder still keeps a 1-bit counter.
    function automatic int cnt_width(input int ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

endpackage

// File: rtl/adder_digit_serial_if.sv
// rtl/adder_digit_serial_if.sv - operand/result handshake bundle for the digit-serial adder
interface adder_digit_serial_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/adder_ripple_slice.sv
// rtl/adder_ripple_slice.sv - DIGIT-bit ripple-carry chain of full adders
module adder_ripple_slice #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    input  logic             carry_i,
    output logic [DIGIT-1:0] sum_o,
    output logic             carry_o
);
    logic [DIGIT:0] carry;

    assign carry[0] = carry_i;

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        full_adder u_fa (
            .a_i     (a_i[i]),
            .b_i     (b_i[i]),
            .carry_i (carry[i]),
            .sum_o   (sum_o[i]),
            .carry_o (carry[i+1])
        );
    end

    assign carry_o = carry[DIGIT];
endmodule

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic carry_i,
    output logic sum_o,
    output logic carry_o
);
    assign sum_o   = a_i ^ b_i ^ carry_i;
    assign carry_o = (a_i & b_i) | (carry_i & (a_i ^ b_i));
endmodule

// File: rtl/adder_digit_serial.sv
// rtl/adder_digit_serial.sv - adds WIDTH-bit operands DIGIT bits per clock with valid/ready handshakes
module adder_digit_serial
    import adder_digit_serial_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    adder_digit_serial_if.slave   bus
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = cnt_width(NDIG);
    localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             cout_q;
    logic             ovf_q;

    int unsigned      dig_base;
    logic [DIGIT-1:0] slice_a;
    logic [DIGIT-1:0] slice_b;
    logic [DIGIT-1:0] slice_sum;
    logic             slice_carry;

    always_comb begin
        dig_base = 32'(cnt_q) * DIGIT;
        slice_a  = a_q[dig_base +: DIGIT];
        slice_b  = b_q[dig_base +: DIGIT];
    end

    adder_ripple_slice #(.DIGIT(DIGIT)) u_slice (
        .a_i     (slice_a),
        .b_i     (slice_b),
        .carry_i (carry_q),
        .sum_o   (slice_sum),
        .carry_o (slice_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        carry_q <= bus.cin;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_q[dig_base +: DIGIT] <= slice_sum;
                    carry_q                  <= slice_carry;
                    // The top digit carries the result MSB, so ovf is decided on this edge.
                    if (cnt_q == LAST_DIG) begin
                        cout_q  <= slice_carry;
                        ovf_q   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                   (slice_sum[DIGIT-1] != a_q[WIDTH-1]);
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule
